// File: rtl/sensor_nivel_agua.sv
// ----------------------------------------------------------------------------
// sensor_nivel_agua
//
// Ultrasonic (HC-SR04 style) water-level measurement stage for the
// coffee-maker control unit (UC). On a medir pulse it issues a trigger pulse
// and times the echo width. The width is converted to centimetres and the
// result is reported back to the UC. A smaller distance means more water.
//
// Ports:
//   clock         in   system clock
//   reset         in   synchronous, active-high reset
//   zera          in   clear request from the UC (same effect as reset)
//   medir         in   one-cycle start pulse, honoured only when idle
//   echo          in   asynchronous sensor echo (synchronised internally)
//   trigger       out  sensor trigger, high for TRIGGER_CYCLES cycles
//   pronto        out  one-cycle pulse: measurement complete
//   suficiente    out  distancia_cm <= LIMIAR_CM, held after pronto
//   timeout       out  one-cycle pulse: no complete echo inside the window
//   distancia_cm  out  last measured distance in cm, saturating at 511
//   db_estado     out  current state encoding (debug)
// ----------------------------------------------------------------------------
module sensor_nivel_agua #(
    parameter int TRIGGER_CYCLES = 500,
    parameter int CYCLES_PER_CM  = 2941,
    parameter int LIMIAR_CM      = 10,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       zera,
    input  logic       medir,
    input  logic       echo,
    output logic       trigger,
    output logic       pronto,
    output logic       suficiente,
    output logic       timeout,
    output logic [8:0] distancia_cm,
    output logic [2:0] db_estado
);

    localparam int TRIG_W = (TRIGGER_CYCLES > 1) ? $clog2(TRIGGER_CYCLES + 1) : 1;
    localparam int CPC_W  = (CYCLES_PER_CM  > 1) ? $clog2(CYCLES_PER_CM  + 1) : 1;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LIM_C  = (LIMIAR_CM > 511) ? 511 : LIMIAR_CM;

    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIGGER_CYCLES - 1);
    localparam logic [CPC_W-1:0]  CPC_LAST  = CPC_W'(CYCLES_PER_CM - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]        LIMIAR_V  = 9'(LIM_C);

    typedef enum logic [2:0] {
        ST_OCIOSO        = 3'd0,
        ST_ENVIA_TRIGGER = 3'd1,
        ST_ESPERA_ECHO   = 3'd2,
        ST_MEDE_ECHO     = 3'd3,
        ST_CONCLUIDO     = 3'd4,
        ST_ERRO_TIMEOUT  = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_echo_meta;
    logic                r_echo_s;
    logic [TRIG_W-1:0]   r_trig_cnt;
    logic [CPC_W-1:0]    r_cm_cnt;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [8:0]          r_dist;
    logic                r_trigger;
    logic                r_pronto;
    logic                r_timeout;
    logic                r_suficiente;

    logic                w_cm_wrap;
    logic [8:0]          w_dist_inc;
    logic                w_tmo_hit;

    // Two-flop synchroniser for the asynchronous echo line.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_echo_meta <= 1'b0;
            r_echo_s    <= 1'b0;
        end else begin
            r_echo_meta <= echo;
            r_echo_s    <= r_echo_meta;
        end
    end

    assign w_cm_wrap  = (r_cm_cnt == CPC_LAST);
    assign w_dist_inc = (r_dist == 9'h1FF) ? r_dist : r_dist + 9'd1;
    assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge clock) begin
        if (reset || zera) begin
            r_state      <= ST_OCIOSO;
            r_trig_cnt   <= '0;
            r_cm_cnt     <= '0;
            r_tmo_cnt    <= '0;
            r_dist       <= '0;
            r_trigger    <= 1'b0;
            r_pronto     <= 1'b0;
            r_timeout    <= 1'b0;
            r_suficiente <= 1'b0;
        end else begin
            r_pronto  <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_OCIOSO: begin
                    if (medir) begin
                        r_state      <= ST_ENVIA_TRIGGER;
                        r_trigger    <= 1'b1;
                        r_trig_cnt   <= '0;
                        r_suficiente <= 1'b0;
                        r_dist       <= '0;
                    end
                end
                ST_ENVIA_TRIGGER: begin
                    if (r_trig_cnt == TRIG_LAST) begin
                        r_trigger <= 1'b0;
                        r_state   <= ST_ESPERA_ECHO;
                        r_tmo_cnt <= '0;
                        r_cm_cnt  <= '0;
                    end else begin
                        r_trig_cnt <= r_trig_cnt + TRIG_W'(1);
                    end
                end
                ST_ESPERA_ECHO: begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    if (w_tmo_hit) begin
                        r_state      <= ST_ERRO_TIMEOUT;
                        r_timeout    <= 1'b1;
                        r_dist       <= '0;
                        r_suficiente <= 1'b0;
                    end else if (r_echo_s) begin
                        // The cycle that detects the rising echo is itself
                        // an echo-high cycle, so it is counted here.
                        r_state <= ST_MEDE_ECHO;
                        if (w_cm_wrap) begin
                            r_cm_cnt <= '0;
                            r_dist   <= w_dist_inc;
                        end else begin
                            r_cm_cnt <= r_cm_cnt + CPC_W'(1);
                        end
                    end
                end
                ST_MEDE_ECHO: begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    if (w_tmo_hit) begin
                        // An echo still high here is abandoned.
                        r_state      <= ST_ERRO_TIMEOUT;
                        r_timeout    <= 1'b1;
                        r_dist       <= '0;
                        r_suficiente <= 1'b0;
                    end else if (!r_echo_s) begin
                        r_state      <= ST_CONCLUIDO;
                        r_pronto     <= 1'b1;
                        r_suficiente <= (r_dist <= LIMIAR_V);
                    end else if (w_cm_wrap) begin
                        r_cm_cnt <= '0;
                        r_dist   <= w_dist_inc;
                    end else begin
                        r_cm_cnt <= r_cm_cnt + CPC_W'(1);
                    end
                end
                ST_CONCLUIDO: begin
                    r_state <= ST_OCIOSO;
                end
                ST_ERRO_TIMEOUT: begin
                    r_state <= ST_OCIOSO;
                end
                default: begin
                    r_state <= ST_OCIOSO;
                end
            endcase
        end
    end

    assign trigger      = r_trigger;
    assign pronto       = r_pronto;
    assign timeout      = r_timeout;
    assign suficiente   = r_suficiente;
    assign distancia_cm = r_dist;
    assign db_estado    = r_state;

endmodule

// File: tb/tb_sensor_nivel_agua.sv
// ----------------------------------------------------------------------------
// tb_sensor_nivel_agua
//
// Directed bench for sensor_nivel_agua with small parameters
// (TRIGGER_CYCLES=4, CYCLES_PER_CM=10, LIMIAR_CM=5, TIMEOUT_CYCLES=200).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_sensor_nivel_agua;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       zera  = 1'b0;
    logic       medir = 1'b0;
    logic       echo  = 1'b0;
    logic       trigger;
    logic       pronto;
    logic       suficiente;
    logic       timeout;
    logic [8:0] distancia_cm;
    logic [2:0] db_estado;

    int n_assert = 0;
    int n_fail   = 0;

    sensor_nivel_agua #(
        .TRIGGER_CYCLES(4),
        .CYCLES_PER_CM (10),
        .LIMIAR_CM     (5),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .zera        (zera),
        .medir       (medir),
        .echo        (echo),
        .trigger     (trigger),
        .pronto      (pronto),
        .suficiente  (suficiente),
        .timeout     (timeout),
        .distancia_cm(distancia_cm),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse medir and run through the 4-cycle trigger; ends just after the
    // edge on which the trigger falls.
    task automatic start_meas();
        medir = 1'b1;
        tick();
        medir = 1'b0;
        repeat (4) tick();
    endtask

    task automatic run_window(input int n, output int np, output int nt,
                              output int both, output logic [8:0] d,
                              output logic s);
        np = 0; nt = 0; both = 0; d = '0; s = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (pronto) begin
                np++;
                d = distancia_cm;
                s = suficiente;
            end
            if (timeout) nt++;
            if (pronto && timeout) both++;
        end
    endtask

    // Tick until timeout is seen (or budget ends); at = cycle index of it.
    task automatic wait_timeout(input int budget, output int at, output int np);
        at = 0; np = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (pronto) np++;
            if (timeout) begin
                at = i;
                break;
            end
        end
    endtask

    int         np, nt, both, at, trig_bad;
    logic [8:0] d;
    logic       s;

    initial begin
        // ---------------- 1: reset and trigger pulse ----------------
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_state", db_estado, 0);
        chk("rst_trigger", trigger, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_suf", suficiente, 0);
        chk("rst_dist", distancia_cm, 0);
        chk("idle_no_trigger", trigger, 0);

        medir = 1'b1;
        tick();
        medir = 1'b0;
        chk("t1_state_trig", db_estado, 1);
        trig_bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (trigger !== 1'b1 || pronto || timeout || suficiente || distancia_cm != 0)
                trig_bad++;
            tick();
        end
        chk("t1_trigger_4cyc", trig_bad, 0);
        chk("t1_trigger_low", trigger, 0);
        chk("t1_state_espera", db_estado, 2);

        // ---------------- 2: 37-cycle echo -> 3 cm, enough ----------------
        echo = 1'b1;
        repeat (37) tick();
        echo = 1'b0;
        run_window(15, np, nt, both, d, s);
        chk("t2_pronto_count", np, 1);
        chk("t2_no_timeout", nt, 0);
        chk("t2_dist", d, 3);
        chk("t2_suf_at_pronto", s, 1);
        chk("t2_state_idle", db_estado, 0);
        chk("t2_suf_held", suficiente, 1);
        chk("t2_dist_held", distancia_cm, 3);

        // ---------------- 3: medir clears, 80-cycle echo -> 8 cm ----------------
        medir = 1'b1;
        tick();
        medir = 1'b0;
        chk("t3_medir_clr_suf", suficiente, 0);
        chk("t3_medir_clr_dist", distancia_cm, 0);
        repeat (4) tick();
        chk("t3_state_espera", db_estado, 2);
        echo = 1'b1;
        repeat (80) tick();
        echo = 1'b0;
        run_window(15, np, nt, both, d, s);
        chk("t3_pronto_count", np, 1);
        chk("t3_dist", d, 8);
        chk("t3_suf", s, 0);
        chk("t3_dist_held", distancia_cm, 8);
        medir = 1'b1;
        tick();
        medir = 1'b0;
        chk("t3_second_medir_clr_dist", distancia_cm, 0);
        chk("t3_second_medir_clr_suf", suficiente, 0);

        // ---------------- 4a: no echo -> timeout after 200 cycles ----------------
        repeat (4) tick();
        chk("t4_trigger_low", trigger, 0);
        wait_timeout(260, at, np);
        chk("t4_timeout_at", at, 200);
        chk("t4_no_pronto", np, 0);
        chk("t4_state_erro", db_estado, 5);
        tick();
        chk("t4_timeout_pulse", timeout, 0);
        chk("t4_state_idle", db_estado, 0);

        // ---------------- 4b: echo stuck high 250 cycles ----------------
        start_meas();
        echo = 1'b1;
        wait_timeout(260, at, np);
        chk("t4b_timeout_at", at, 200);
        chk("t4b_no_pronto", np, 0);
        chk("t4b_dist", distancia_cm, 0);
        chk("t4b_suf", suficiente, 0);
        run_window(50, np, nt, both, d, s);
        echo = 1'b0;
        chk("t4b_no_late_pronto", np + nt, 0);
        repeat (3) tick();
        chk("t4b_state_idle", db_estado, 0);

        // ---------------- 5: zera mid-measurement ----------------
        start_meas();
        echo = 1'b1;
        repeat (20) tick();
        chk("t5_state_mede", db_estado, 3);
        zera  = 1'b1;
        medir = 1'b1;
        tick();
        zera  = 1'b0;
        medir = 1'b0;
        chk("t5_state_idle", db_estado, 0);
        chk("t5_outputs_clear",
            {23'd0, trigger, pronto, timeout, suficiente, 5'd0} | {23'd0, distancia_cm}, 0);
        echo = 1'b0;
        repeat (3) tick();
        chk("t5_still_idle", db_estado, 0);
        start_meas();
        echo = 1'b1;
        repeat (25) tick();
        echo = 1'b0;
        run_window(15, np, nt, both, d, s);
        chk("t5_pronto_count", np, 1);
        chk("t5_dist", d, 2);
        chk("t5_suf", s, 1);

        // ---------------- 6: medir ignored when busy, 9-cycle echo ----------------
        medir = 1'b1;
        tick();
        medir = 1'b0;
        trig_bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (trigger !== 1'b1) trig_bad++;
            if (i == 1) medir = 1'b1;
            if (i == 2) medir = 1'b0;
            tick();
        end
        chk("t6_trigger_4cyc", trig_bad, 0);
        chk("t6_trigger_low", trigger, 0);
        chk("t6_state_espera", db_estado, 2);
        echo = 1'b1;
        repeat (4) tick();
        chk("t6_state_mede", db_estado, 3);
        medir = 1'b1;
        tick();
        medir = 1'b0;
        repeat (4) tick();
        echo = 1'b0;
        run_window(30, np, nt, both, d, s);
        chk("t6_pronto_count", np, 1);
        chk("t6_no_timeout", nt, 0);
        chk("t6_never_both", both, 0);
        chk("t6_dist", d, 0);
        chk("t6_suf", s, 1);
        chk("t6_no_new_trigger", trigger, 0);
        chk("t6_state_idle", db_estado, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
